// File: rtl/block_state_manager_pkg.sv
// Package: block_state_manager_pkg
// Shared breakout brick-field geometry, the default start pattern and the
// small types used by the brick state manager and its address mapper.
package block_state_manager_pkg;

    localparam int unsigned GRID_COLS    = 13;
    localparam int unsigned GRID_ROWS    = 16;
    localparam logic [9:0]  GRID_X0      = 10'd64;
    localparam logic [8:0]  GRID_Y0      = 9'd48;
    localparam int unsigned BRICK_W_LOG2 = 4;
    localparam int unsigned BRICK_H_LOG2 = 3;
    localparam int unsigned NBRICKS      = GRID_COLS * GRID_ROWS;

    // Full wall at power-up; bit index = row*GRID_COLS + col, row 0 = top.
    localparam logic [NBRICKS-1:0] DEFAULT_PATTERN = '1;

    typedef logic [7:0] brick_idx_t;
    typedef logic [7:0] score_t;

    // Score saturates at 255 instead of wrapping.
    function automatic score_t score_inc(input score_t s);
        return (s == 8'hFF) ? s : s + 8'd1;
    endfunction

endpackage

// File: rtl/block_state_manager_if.sv
// Interface: block_state_manager_if
// Bundles the video-position / event inputs and the brick-field outputs of
// block_state_manager.
//   hpos, vpos    pixel position from vga_timing
//   frame_pulse   1-cycle pulse at start of vertical blanking
//   hit           ball and brick drawn on the same pixel
//   restart       synchronous reload request
//   block_state   1 = brick present (N bits)
//   destroyed     1-cycle pulse after a brick is cleared
//   score         saturating count of cleared bricks
//   all_clear     registered "no bricks left"
// master = producer of the inputs (game logic / bench), slave = the manager.
interface block_state_manager_if #(
    parameter int unsigned N = block_state_manager_pkg::NBRICKS
) ();
    logic [9:0]   hpos;
    logic [8:0]   vpos;
    logic         frame_pulse;
    logic         hit;
    logic         restart;
    logic [N-1:0] block_state;
    logic         destroyed;
    logic [7:0]   score;
    logic         all_clear;

    modport master (
        output hpos, vpos, frame_pulse, hit, restart,
        input  block_state, destroyed, score, all_clear
    );

    modport slave (
        input  hpos, vpos, frame_pulse, hit, restart,
        output block_state, destroyed, score, all_clear
    );
endinterface

// File: rtl/block_state_manager_brick_addr.sv
// Module: brick_addr
// Combinational map from a pixel position to the brick under it.
//   hpos, vpos   in   pixel column / row
//   idx          out  row*COLS + col (valid only when in_grid)
//   in_grid      out  pixel lies inside the brick field
// Brick sizes are powers of two, so column/row are shifts and the index
// needs only a multiply by the constant COLS.
module brick_addr
    import block_state_manager_pkg::*;
#(
    parameter int unsigned COLS   = GRID_COLS,
    parameter int unsigned ROWS   = GRID_ROWS,
    parameter logic [9:0]  X0     = GRID_X0,
    parameter logic [8:0]  Y0     = GRID_Y0,
    parameter int unsigned W_LOG2 = BRICK_W_LOG2,
    parameter int unsigned H_LOG2 = BRICK_H_LOG2
) (
    input  logic [9:0] hpos,
    input  logic [8:0] vpos,
    output brick_idx_t idx,
    output logic       in_grid
);
    logic [9:0] dx;
    logic [8:0] dy;
    logic [9:0] col;
    logic [8:0] row;

    always_comb begin
        dx  = hpos - X0;
        dy  = vpos - Y0;
        col = dx >> W_LOG2;
        row = dy >> H_LOG2;
        // dx/dy wrap when left of / above the field, hence the explicit
        // origin comparisons in addition to the col/row limits.
        in_grid = (hpos >= X0) && (vpos >= Y0) &&
                  (32'(col) < COLS) && (32'(row) < ROWS);
        idx = 8'(row) * 8'(COLS) + 8'(col);
    end
endmodule

// File: rtl/block_state_manager.sv
// Module: block_state_manager
// Owns the breakout brick field. The first in-grid ball/brick overlap of a
// frame is latched as a pending brick index; on the next frame_pulse that
// brick is cleared (if still present), the score is bumped and destroyed
// pulses for one cycle. restart reloads the start pattern and clears score.
//   clk, rst   pixel clock, asynchronous active-high reset
//   bus        block_state_manager_if.slave (see interface for signals)
module block_state_manager
    import block_state_manager_pkg::*;
#(
    parameter int unsigned              COLS   = GRID_COLS,
    parameter int unsigned              ROWS   = GRID_ROWS,
    parameter logic [9:0]               X0     = GRID_X0,
    parameter logic [8:0]               Y0     = GRID_Y0,
    parameter int unsigned              W_LOG2 = BRICK_W_LOG2,
    parameter int unsigned              H_LOG2 = BRICK_H_LOG2,
    parameter logic [COLS*ROWS-1:0]     INIT   = DEFAULT_PATTERN
) (
    input logic                  clk,
    input logic                  rst,
    block_state_manager_if.slave bus
);
    localparam int unsigned N = COLS * ROWS;

    brick_idx_t hit_idx;
    logic       hit_in_grid;

    brick_addr #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .X0     (X0),
        .Y0     (Y0),
        .W_LOG2 (W_LOG2),
        .H_LOG2 (H_LOG2)
    ) u_brick_addr (
        .hpos    (bus.hpos),
        .vpos    (bus.vpos),
        .idx     (hit_idx),
        .in_grid (hit_in_grid)
    );

    logic [N-1:0] state_q,     state_d;
    score_t       score_q,     score_d;
    logic         destroyed_q, destroyed_d;
    logic         all_clear_q, all_clear_d;
    logic         pend_vld_q,  pend_vld_d;
    brick_idx_t   pend_idx_q,  pend_idx_d;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        destroyed_d = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;

        if (bus.restart) begin
            state_d    = INIT;
            score_d    = '0;
            pend_vld_d = 1'b0;
        end else if (bus.frame_pulse) begin
            // Commit uses the index latched earlier; a hit on this same
            // cycle is dropped because pending is cleared unconditionally.
            if (pend_vld_q && state_q[pend_idx_q]) begin
                state_d[pend_idx_q] = 1'b0;
                destroyed_d         = 1'b1;
                score_d             = score_inc(score_q);
            end
            pend_vld_d = 1'b0;
        end else if (bus.hit && hit_in_grid && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_idx_d = hit_idx;
        end

        all_clear_d = (state_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            score_q     <= '0;
            destroyed_q <= 1'b0;
            all_clear_q <= (INIT == '0);
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            destroyed_q <= destroyed_d;
            all_clear_q <= all_clear_d;
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
        end
    end

    assign bus.block_state = state_q;
    assign bus.score       = score_q;
    assign bus.destroyed   = destroyed_q;
    assign bus.all_clear   = all_clear_q;
endmodule

// File: tb/tb_block_state_manager.sv
// Bench for block_state_manager: three instances (full default wall, a
// single-brick wall, and a 16x16 wall large enough to reach score 255).
module tb_block_state_manager;
    import block_state_manager_pkg::*;

    localparam int unsigned NA = NBRICKS;
    localparam int unsigned NC = 256;
    localparam logic [NA-1:0] INIT_B = {1'b1, {(NA-1){1'b0}}};
    localparam logic [NC-1:0] INIT_C = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_state_manager_if #(.N(NA)) if_a ();
    block_state_manager_if #(.N(NA)) if_b ();
    block_state_manager_if #(.N(NC)) if_c ();

    block_state_manager #(.INIT(DEFAULT_PATTERN)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    block_state_manager #(.INIT(INIT_B))          dut_b (.clk(clk), .rst(rst), .bus(if_b));
    block_state_manager #(.COLS(16), .ROWS(16), .INIT(INIT_C)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for dut_a ----------------
    bit m_state[NA];
    int m_score;
    bit m_destroyed;
    bit m_pend;
    int m_pidx;

    function automatic bit geom(input int h, input int v, output int idx);
        int col, row;
        idx = 0;
        if (h < 64 || v < 48) return 1'b0;
        col = (h - 64) / 16;
        row = (v - 48) / 8;
        if (col >= 13 || row >= 16) return 1'b0;
        idx = row * 13 + col;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) m_state[i] = 1'b1;
        m_score = 0;
        m_destroyed = 1'b0;
        m_pend = 1'b0;
        m_pidx = 0;
    endtask

    task automatic model_step(input int h, input int v, input bit fp, input bit ht, input bit rs);
        int idx;
        bit ing;
        ing = geom(h, v, idx);
        m_destroyed = 1'b0;
        if (rs) begin
            for (int i = 0; i < NA; i++) m_state[i] = 1'b1;
            m_score = 0;
            m_pend = 1'b0;
        end else if (fp) begin
            if (m_pend && m_state[m_pidx]) begin
                m_state[m_pidx] = 1'b0;
                m_destroyed = 1'b1;
                if (m_score < 255) m_score++;
            end
            m_pend = 1'b0;
        end else if (ht && ing && !m_pend) begin
            m_pend = 1'b1;
            m_pidx = idx;
        end
    endtask

    function automatic logic [255:0] model_vec();
        logic [255:0] v = '0;
        for (int i = 0; i < NA; i++) v[i] = m_state[i];
        return v;
    endfunction

    function automatic logic model_empty();
        for (int i = 0; i < NA; i++) if (m_state[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_model();
        chk("a_state_vs_model",     256'(if_a.block_state), model_vec());
        chk("a_score_vs_model",     256'(if_a.score),       256'(m_score));
        chk("a_destroyed_vs_model", 256'(if_a.destroyed),   256'(m_destroyed));
        chk("a_all_clear_vs_model", 256'(if_a.all_clear),   256'(model_empty()));
    endtask

    // Drive one cycle on the selected instance (0=a, 1=b, 2=c); others idle.
    task automatic apply(input int sel, input logic [9:0] h, input logic [8:0] v,
                         input logic fp, input logic ht, input logic rs);
        @(negedge clk);
        if_a.hit = 1'b0; if_a.frame_pulse = 1'b0; if_a.restart = 1'b0;
        if_b.hit = 1'b0; if_b.frame_pulse = 1'b0; if_b.restart = 1'b0;
        if_c.hit = 1'b0; if_c.frame_pulse = 1'b0; if_c.restart = 1'b0;
        case (sel)
            0: begin if_a.hpos = h; if_a.vpos = v; if_a.frame_pulse = fp; if_a.hit = ht; if_a.restart = rs; end
            1: begin if_b.hpos = h; if_b.vpos = v; if_b.frame_pulse = fp; if_b.hit = ht; if_b.restart = rs; end
            default: begin if_c.hpos = h; if_c.vpos = v; if_c.frame_pulse = fp; if_c.hit = ht; if_c.restart = rs; end
        endcase
        @(posedge clk);
        if (sel == 0) model_step(int'(h), int'(v), fp, ht, rs);
        #1;
        if (sel == 0) check_model();
    endtask

    typedef struct {
        logic [9:0] h;
        logic [8:0] v;
        logic       fp;
        logic       ht;
        logic       rs;
        logic       exp_d;
        int         exp_score;
        int         bidx;
        logic       exp_bit;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        if_a.hpos = '0; if_a.vpos = '0; if_a.hit = 0; if_a.frame_pulse = 0; if_a.restart = 0;
        if_b.hpos = '0; if_b.vpos = '0; if_b.hit = 0; if_b.frame_pulse = 0; if_b.restart = 0;
        if_c.hpos = '0; if_c.vpos = '0; if_c.hit = 0; if_c.frame_pulse = 0; if_c.restart = 0;
        model_reset();

        // Reset state
        #12;
        chk("rst_a_state",     256'(if_a.block_state), {48'h0, {208{1'b1}}});
        chk("rst_a_score",     256'(if_a.score), 256'd0);
        chk("rst_a_all_clear", 256'(if_a.all_clear), 256'd0);
        chk("rst_a_destroyed", 256'(if_a.destroyed), 256'd0);
        chk("rst_b_state",     256'(if_b.block_state), 256'(INIT_B));
        chk("rst_b_all_clear", 256'(if_b.all_clear), 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table on dut_a (full wall)
        vecs = '{
            '{10'd64,  9'd48,  0,1,0, 0,0, 0,  1},   // capture idx 0
            '{10'd0,   9'd0,   1,0,0, 1,1, 0,  0},   // commit
            '{10'd0,   9'd0,   0,0,0, 0,1, 0,  0},   // pulse is one cycle
            '{10'd80,  9'd56,  0,1,0, 0,1, 14, 1},   // first hit: idx 14
            '{10'd96,  9'd48,  0,1,0, 0,1, 2,  1},   // second hit ignored
            '{10'd0,   9'd0,   1,0,0, 1,2, 14, 0},
            '{10'd0,   9'd0,   0,0,0, 0,2, 2,  1},
            '{10'd63,  9'd48,  0,1,0, 0,2, 1,  1},   // left of field
            '{10'd0,   9'd0,   1,0,0, 0,2, 1,  1},
            '{10'd64,  9'd176, 0,1,0, 0,2, 195,1},   // row 16
            '{10'd0,   9'd0,   1,0,0, 0,2, 195,1},
            '{10'd272, 9'd50,  0,1,0, 0,2, 12, 1},   // col 13
            '{10'd0,   9'd0,   1,0,0, 0,2, 12, 1},
            '{10'd271, 9'd175, 0,1,0, 0,2, 207,1},   // last brick of field
            '{10'd0,   9'd0,   1,0,0, 1,3, 207,0},
            '{10'd64,  9'd56,  0,1,0, 0,3, 13, 1},   // capture idx 13
            '{10'd80,  9'd48,  1,1,0, 1,4, 13, 0},   // hit with pulse: old idx wins
            '{10'd0,   9'd0,   1,0,0, 0,4, 1,  1},   // dropped hit never commits
            '{10'd96,  9'd56,  0,1,0, 0,4, 15, 1},   // capture idx 15
            '{10'd0,   9'd0,   1,0,1, 0,0, 0,  1},   // restart beats commit
            '{10'd96,  9'd56,  0,1,1, 0,0, 15, 1},   // held restart blocks capture
            '{10'd0,   9'd0,   1,0,0, 0,0, 15, 1},
            '{10'd64,  9'd48,  0,1,0, 0,0, 0,  1},
            '{10'd0,   9'd0,   1,0,0, 1,1, 0,  0},
            '{10'd64,  9'd48,  0,1,0, 0,1, 0,  0},   // same brick again
            '{10'd0,   9'd0,   1,0,0, 0,1, 0,  0}
        };
        foreach (vecs[i]) begin
            logic [NA-1:0] bs;
            apply(0, vecs[i].h, vecs[i].v, vecs[i].fp, vecs[i].ht, vecs[i].rs);
            bs = if_a.block_state;
            chk($sformatf("vec%0d_destroyed", i), 256'(if_a.destroyed), 256'(vecs[i].exp_d));
            chk($sformatf("vec%0d_score", i),     256'(if_a.score),     256'(vecs[i].exp_score));
            chk($sformatf("vec%0d_bit%0d", i, vecs[i].bidx), 256'(bs[vecs[i].bidx]), 256'(vecs[i].exp_bit));
        end

        // Single-brick wall: clearing it raises all_clear; re-hit does nothing
        apply(1, 10'd256, 9'd168, 0, 1, 0);
        apply(1, 10'd0, 9'd0, 1, 0, 0);
        chk("b_state_empty", 256'(if_b.block_state), 256'd0);
        chk("b_all_clear",   256'(if_b.all_clear), 256'd1);
        chk("b_score",       256'(if_b.score), 256'd1);
        chk("b_destroyed",   256'(if_b.destroyed), 256'd1);
        apply(1, 10'd256, 9'd168, 0, 1, 0);
        apply(1, 10'd0, 9'd0, 1, 0, 0);
        chk("b_rehit_destroyed", 256'(if_b.destroyed), 256'd0);
        chk("b_rehit_score",     256'(if_b.score), 256'd1);
        chk("b_rehit_all_clear", 256'(if_b.all_clear), 256'd1);

        // 256-brick wall: score saturates, destroyed still pulses
        for (int i = 0; i < 256; i++) begin
            apply(2, 10'(64 + (i % 16) * 16), 9'(48 + (i / 16) * 8), 0, 1, 0);
            apply(2, 10'd0, 9'd0, 1, 0, 0);
            if (i == 253) chk("c_score_254", 256'(if_c.score), 256'd254);
            if (i == 254) begin
                chk("c_score_255",     256'(if_c.score), 256'd255);
                chk("c_destroyed_255", 256'(if_c.destroyed), 256'd1);
            end
            if (i == 255) begin
                chk("c_sat_score",     256'(if_c.score), 256'd255);
                chk("c_sat_destroyed", 256'(if_c.destroyed), 256'd1);
                chk("c_sat_all_clear", 256'(if_c.all_clear), 256'd1);
                chk("c_sat_state",     256'(if_c.block_state), 256'd0);
            end
        end

        // Random traffic on dut_a against the model
        for (int n = 0; n < 3000; n++) begin
            apply(0, 10'($urandom_range(50, 290)), 9'($urandom_range(40, 185)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        // Asynchronous reset mid-frame discards the pending hit
        apply(0, 10'd0, 9'd0, 0, 0, 1);
        apply(0, 10'd64, 9'd48, 0, 1, 0);
        @(negedge clk);
        if_a.hit = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 256'(if_a.block_state), {48'h0, {208{1'b1}}});
        chk("async_rst_score", 256'(if_a.score), 256'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(0, 10'd0, 9'd0, 1, 0, 0);
        chk("after_rst_no_destroyed", 256'(if_a.destroyed), 256'd0);
        chk("after_rst_bit0", 256'(if_a.block_state[0]), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end
endmodule
